// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types for the core pipeline.
// Imported by the fetch stage and its buffer.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} pairs.
// Flush empties it in one cycle; reset also clears storage.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int AW = XLEN,
  parameter int DW = ILEN,
  parameter int DEPTH = 2,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_instr,
  input  logic [AW-1:0] push_pc,
  input  logic          pop,
  output logic [DW-1:0] head_instr,
  output logic [AW-1:0] head_pc,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{instr: push_instr, pc: push_pc};
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head_instr = mem[rd_ptr].instr;
  assign head_pc    = mem[rd_ptr].pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && !flush && count == '0));
endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, 1-cycle imem issue, output buffer.
// Redirects flush wrong-path work and restart at the target.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_en,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic [ADDRESS_WIDTH-1:0] instr_pc4
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] req_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [DATA_WIDTH-1:0] head_instr;
  logic [AW-1:0] head_pc;
  logic [AW-1:0] target;
  logic [CW:0]   level;
  logic          pop;
  logic          push;
  logic          issue_ok;
  logic          unused_lsb;

  assign unused_lsb = &redirect_pc[1:0];
  assign target = {redirect_pc[AW-1:2], 2'b00};

  assign instr_valid = !rst && !redirect && (count != '0);
  assign pop  = instr_valid && instr_ready;
  assign push = inflight && !redirect && !rst;

  // Slots reserved by in-flight reads count as occupied.
  assign level = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue_ok = (level < (CW+1)'(DEPTH)) ||
                    ((level == (CW+1)'(DEPTH)) && pop);

  assign imem_en = !rst && (redirect || issue_ok);

  always_comb begin
    imem_addr = fetch_pc;
    if (rst) imem_addr = RESET_PC;
    else if (redirect) imem_addr = target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        fetch_pc <= imem_addr + AW'(4);
        req_pc   <= imem_addr;
      end
    end
  end

  fetch_fifo #(
    .AW(AW),
    .DW(DATA_WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect),
    .push(push),
    .push_instr(imem_rdata),
    .push_pc(req_pc),
    .pop(pop),
    .head_instr(head_instr),
    .head_pc(head_pc),
    .count(count)
  );

  assign instr     = rst ? '0 : head_instr;
  assign instr_pc  = rst ? '0 : head_pc;
  assign instr_pc4 = rst ? '0 : head_pc + AW'(4);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, stall, redirect,
// reset and PC wrap, with a tagged-word instruction memory.
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst = 1'b1;
  logic        en;
  logic [31:0] addr;
  logic [31:0] rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;

  logic        rst2 = 1'b1;
  logic        en2;
  logic [31:0] addr2;
  logic [31:0] rdata2 = 32'h0;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;
  logic        valid2;
  logic        ready2 = 1'b0;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic [31:0] pc42;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_en(en), .imem_addr(addr),
    .imem_rdata(rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(valid),
    .instr_ready(ready), .instr(instr), .instr_pc(pc),
    .instr_pc4(pc4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .imem_en(en2), .imem_addr(addr2),
    .imem_rdata(rdata2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .instr_valid(valid2),
    .instr_ready(ready2), .instr(instr2), .instr_pc(pc2),
    .instr_pc4(pc42)
  );

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always_ff @(posedge clk) begin
    rdata  <= en ? tag(addr) : 32'hBAD0_BAD0;
    rdata2 <= en2 ? tag(addr2) : 32'hBAD0_BAD0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    #3;
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", en); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc); end
    checks++; if (pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp 0", pc4); end
    checks++; if (addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL rst_addr2 got %h exp fffffff8", addr2); end
  endtask

  // Release reset with ready=1: one issue and one delivery per cycle.
  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      tick();
      rst = 1'b0;
      ready = 1'b1;
      #3;
      checks++; if (en !== 1'b1) begin errors++; $display("FAIL stream_en[%0d] got %b exp 1", i, en); end
      checks++; if (addr !== 32'(4 * i)) begin errors++; $display("FAIL stream_addr[%0d] got %h exp %h", i, addr, 32'(4 * i)); end
      if (i < 2) begin
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid[%0d] got %b exp 0", i, valid); end
      end else begin
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, valid); end
        checks++; if (pc !== 32'(4 * (i - 2))) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, pc, 32'(4 * (i - 2))); end
        checks++; if (pc4 !== 32'(4 * (i - 1))) begin errors++; $display("FAIL stream_pc4[%0d] got %h exp %h", i, pc4, 32'(4 * (i - 1))); end
        checks++; if (instr !== tag(32'(4 * (i - 2)))) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, instr, tag(32'(4 * (i - 2)))); end
      end
    end
  endtask

  // Head is pc 0x10 with 0x14 in flight when decode stalls.
  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      ready = 1'b0;
      #3;
      checks++; if (en !== 1'b0) begin errors++; $display("FAIL stall_en[%0d] got %b exp 0", i, en); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, valid); end
      checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 10", i, pc); end
      checks++; if (instr !== tag(32'h10)) begin errors++; $display("FAIL stall_instr[%0d] got %h exp %h", i, instr, tag(32'h10)); end
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      ready = 1'b1;
      #3;
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL resume_valid[%0d] got %b exp 1", j, valid); end
      checks++; if (pc !== 32'(32'h10 + 4 * j)) begin errors++; $display("FAIL resume_pc[%0d] got %h exp %h", j, pc, 32'(32'h10 + 4 * j)); end
      checks++; if (instr !== tag(32'(32'h10 + 4 * j))) begin errors++; $display("FAIL resume_instr[%0d] got %h", j, instr); end
      checks++; if (addr !== 32'(32'h18 + 4 * j)) begin errors++; $display("FAIL resume_addr[%0d] got %h exp %h", j, addr, 32'(32'h18 + 4 * j)); end
    end
  endtask

  // Redirect to tgt (imem sees {tgt[31:2],00}), then check delivery.
  task automatic redirect_to(input logic [31:0] tgt, input logic [31:0] exp_pc);
    tick();
    redirect = 1'b1;
    redirect_pc = tgt;
    #3;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", valid); end
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL redir_en got %b exp 1", en); end
    checks++; if (addr !== exp_pc) begin errors++; $display("FAIL redir_addr got %h exp %h", addr, exp_pc); end
  endtask

  task automatic expect_after_redirect(input logic [31:0] exp_pc);
    tick();
    redirect = 1'b0;
    #3;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL post_redir_valid got %b exp 0 pc %h", valid, pc); end
    checks++; if (addr !== exp_pc + 32'h4) begin errors++; $display("FAIL post_redir_addr got %h exp %h", addr, exp_pc + 32'h4); end
    for (int k = 0; k < 2; k++) begin
      tick();
      #3;
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL redir_dlv_valid[%0d] got %b exp 1", k, valid); end
      checks++; if (pc !== exp_pc + 32'(4 * k)) begin errors++; $display("FAIL redir_dlv_pc[%0d] got %h exp %h", k, pc, exp_pc + 32'(4 * k)); end
      checks++; if (instr !== tag(exp_pc + 32'(4 * k))) begin errors++; $display("FAIL redir_dlv_instr[%0d] got %h", k, instr); end
    end
  endtask

  task automatic test_redirect();
    redirect_to(32'h100, 32'h100);
    expect_after_redirect(32'h100);
  endtask

  task automatic test_back_to_back();
    redirect_to(32'h200, 32'h200);
    redirect_to(32'h300, 32'h300);
    expect_after_redirect(32'h300);
  endtask

  task automatic test_misaligned();
    redirect_to(32'h103, 32'h100);
    expect_after_redirect(32'h100);
  endtask

  // Reset lands with one entry buffered and one read in flight.
  task automatic test_reset_mid();
    tick();
    rst = 1'b1;
    #3;
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL mid_rst_en got %b exp 0", en); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", valid); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL mid_rst_addr got %h exp 0", addr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL mid_rst_pc got %h exp 0", pc); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL mid_rst_instr got %h exp 0", instr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      rst = 1'b0;
      #3;
      checks++; if (addr !== 32'(4 * i)) begin errors++; $display("FAIL restart_addr[%0d] got %h exp %h", i, addr, 32'(4 * i)); end
      checks++; if (valid !== (i == 2)) begin errors++; $display("FAIL restart_valid[%0d] got %b exp %b", i, valid, i == 2); end
    end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL restart_pc got %h exp 0", pc); end
    checks++; if (instr !== tag(32'h0)) begin errors++; $display("FAIL restart_instr got %h exp %h", instr, tag(32'h0)); end
  endtask

  task automatic test_wrap();
    logic [31:0] seq [5];
    seq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 5; i++) begin
      tick();
      rst2 = 1'b0;
      ready2 = 1'b1;
      #3;
      checks++; if (addr2 !== seq[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, addr2, seq[i]); end
      if (i >= 2) begin
        checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL wrap_valid[%0d] got %b exp 1", i, valid2); end
        checks++; if (pc2 !== seq[i-2]) begin errors++; $display("FAIL wrap_pc[%0d] got %h exp %h", i, pc2, seq[i-2]); end
        checks++; if (pc42 !== seq[i-1]) begin errors++; $display("FAIL wrap_pc4[%0d] got %h exp %h", i, pc42, seq[i-1]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
